// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback from the IR opcode.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       irwrite,
  output logic       memwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic       pcen,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } st_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  st_t cur, nxt;
  logic rdy;

  assign rdy   = mem_ready | ~MEM_WAIT_EN;
  assign state = cur;
  assign pcen  = pcwrite | (branch & zero);

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    unique case (cur)
      FETCH:   nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        unique case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYP:      nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = rdy ? MEMWB : MEMRD;
      MEMWB:   nxt = FETCH;
      MEMWR:   nxt = rdy ? FETCH : MEMWR;
      RTYPEEX: nxt = RTYPEWB;
      RTYPEWB: nxt = FETCH;
      BEQEX:   nxt = FETCH;
      ADDIEX:  nxt = ADDIWB;
      ADDIWB:  nxt = FETCH;
      JEX:     nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    illegal_op = 1'b0;
    unique case (cur)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = rdy;
        pcwrite = rdy;
      end
      DECODE: begin
        alusrcb = 2'b11;
        unique case (op)
          OP_LW, OP_SW, OP_RTYP,
          OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          default:               illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller.
// One table row per clock: inputs, expected state and outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       memtoreg, regdst, iord, alusrca;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       irwrite, memwrite, pcwrite, branch, regwrite;
  logic       pcen, illegal_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .iord      (iord),
    .pcsrc     (pcsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .irwrite   (irwrite),
    .memwrite  (memwrite),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .regwrite  (regwrite),
    .pcen      (pcen),
    .illegal_op(illegal_op),
    .state     (state)
  );

  // {memtoreg,regdst,iord,pcsrc,alusrca,alusrcb,aluop,
  //  irwrite,memwrite,pcwrite,branch,regwrite,pcen,illegal_op}
  logic [16:0] outs;
  assign outs = {memtoreg, regdst, iord, pcsrc, alusrca,
                 alusrcb, aluop, irwrite, memwrite, pcwrite,
                 branch, regwrite, pcen, illegal_op};

  localparam logic [16:0] O_FRDY = 17'b0_0_0_00_0_01_00_1_0_1_0_0_1_0;
  localparam logic [16:0] O_FNR  = 17'b0_0_0_00_0_01_00_0_0_0_0_0_0_0;
  localparam logic [16:0] O_DEC  = 17'b0_0_0_00_0_11_00_0_0_0_0_0_0_0;
  localparam logic [16:0] O_ILL  = 17'b0_0_0_00_0_11_00_0_0_0_0_0_0_1;
  localparam logic [16:0] O_MADR = 17'b0_0_0_00_1_10_00_0_0_0_0_0_0_0;
  localparam logic [16:0] O_MRD  = 17'b0_0_1_00_0_00_00_0_0_0_0_0_0_0;
  localparam logic [16:0] O_MWB  = 17'b1_0_0_00_0_00_00_0_0_0_0_1_0_0;
  localparam logic [16:0] O_MWR  = 17'b0_0_1_00_0_00_00_0_1_0_0_0_0_0;
  localparam logic [16:0] O_REX  = 17'b0_0_0_00_1_00_10_0_0_0_0_0_0_0;
  localparam logic [16:0] O_RWB  = 17'b0_1_0_00_0_00_00_0_0_0_0_1_0_0;
  localparam logic [16:0] O_BZ1  = 17'b0_0_0_01_1_00_01_0_0_0_1_0_1_0;
  localparam logic [16:0] O_BZ0  = 17'b0_0_0_01_1_00_01_0_0_0_1_0_0_0;
  localparam logic [16:0] O_AEX  = 17'b0_0_0_00_1_10_00_0_0_0_0_0_0_0;
  localparam logic [16:0] O_AWB  = 17'b0_0_0_00_0_00_00_0_0_0_0_1_0_0;
  localparam logic [16:0] O_JEX  = 17'b0_0_0_10_0_00_00_0_0_1_0_0_1_0;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic        chk;
    logic [3:0]  st;
    logic [16:0] o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [5:0] o_p,
                     input logic z, input logic rdy,
                     input logic chk, input logic [3:0] st,
                     input logic [16:0] o);
    vec_t v;
    v.rst = rst; v.op = o_p; v.z = z; v.rdy = rdy;
    v.chk = chk; v.st = st; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [5:0] o_p,
                       input logic z, input logic rdy);
    @(negedge clk);
    reset = rst; op = o_p; zero = z; mem_ready = rdy;
    #1;
  endtask

  initial begin
    int cyc;
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b1;

    add(1, LW, 0, 1, 0, 0, O_FRDY);
    add(1, LW, 0, 1, 0, 0, O_FRDY);
    // lw: 0,1,2,3,4
    add(0, LW, 0, 1, 1, 0, O_FRDY);
    add(0, LW, 0, 1, 1, 1, O_DEC);
    add(0, LW, 0, 1, 1, 2, O_MADR);
    add(0, LW, 0, 1, 1, 3, O_MRD);
    add(0, LW, 0, 1, 1, 4, O_MWB);
    // fetch stall, then sw with 3 wait cycles
    add(0, SW, 0, 0, 1, 0, O_FNR);
    add(0, SW, 0, 1, 1, 0, O_FRDY);
    add(0, SW, 0, 1, 1, 1, O_DEC);
    add(0, SW, 0, 1, 1, 2, O_MADR);
    add(0, SW, 0, 0, 1, 5, O_MWR);
    add(0, SW, 0, 0, 1, 5, O_MWR);
    add(0, SW, 0, 0, 1, 5, O_MWR);
    add(0, SW, 0, 1, 1, 5, O_MWR);
    // beq taken / not taken
    add(0, BEQ, 1, 1, 1, 0, O_FRDY);
    add(0, BEQ, 1, 1, 1, 1, O_DEC);
    add(0, BEQ, 1, 1, 1, 8, O_BZ1);
    add(0, BEQ, 0, 1, 1, 0, O_FRDY);
    add(0, BEQ, 0, 1, 1, 1, O_DEC);
    add(0, BEQ, 0, 1, 1, 8, O_BZ0);
    // R-type
    add(0, RT, 0, 1, 1, 0, O_FRDY);
    add(0, RT, 0, 1, 1, 1, O_DEC);
    add(0, RT, 0, 1, 1, 6, O_REX);
    add(0, RT, 0, 1, 1, 7, O_RWB);
    // addi
    add(0, ADDI, 0, 1, 1, 0, O_FRDY);
    add(0, ADDI, 0, 1, 1, 1, O_DEC);
    add(0, ADDI, 0, 1, 1, 9, O_AEX);
    add(0, ADDI, 0, 1, 1, 10, O_AWB);
    // j, with zero=0 so pcen comes from pcwrite
    add(0, JMP, 0, 1, 1, 0, O_FRDY);
    add(0, JMP, 0, 1, 1, 1, O_DEC);
    add(0, JMP, 0, 1, 1, 11, O_JEX);
    // illegal op pulses once
    add(0, BAD, 0, 1, 1, 0, O_FRDY);
    add(0, BAD, 0, 1, 1, 1, O_ILL);
    add(0, LW, 0, 1, 1, 0, O_FRDY);
    // reset while waiting in MEMRD
    add(0, LW, 0, 1, 1, 1, O_DEC);
    add(0, LW, 0, 0, 1, 2, O_MADR);
    add(0, LW, 0, 0, 1, 3, O_MRD);
    add(1, LW, 0, 0, 1, 3, O_MRD);
    add(0, LW, 0, 1, 1, 0, O_FRDY);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].rdy);
      if (tbl[i].chk) begin
        cmp($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
        cmp($sformatf("row%0d_outs", i), 32'(outs), 32'(tbl[i].o));
      end
    end

    // Hand sequence: lw cycle count from FETCH back to FETCH
    drive(1, LW, 0, 1);
    drive(0, LW, 0, 1);
    cyc = 0;
    do begin
      drive(0, LW, 0, 1);
      cyc++;
    end while (state != 4'd0 && cyc < 20);
    cmp("lw_cycles", 32'(cyc), 32'd5);

    // Hand sequence: sw stalled in MEMWR, memwrite held, then reset
    drive(0, SW, 0, 1);
    drive(0, SW, 0, 1);
    cyc = 0;
    while (state != 4'd5 && cyc < 10) begin
      drive(0, SW, 0, 0);
      cyc++;
    end
    cmp("sw_reach_memwr", 32'(state), 32'd5);
    for (int k = 0; k < 4; k++) begin
      drive(0, SW, 0, 0);
      cmp($sformatf("sw_hold%0d", k), 32'({state, memwrite, iord}),
          32'({4'd5, 1'b1, 1'b1}));
    end
    drive(1, SW, 0, 0);
    drive(0, SW, 0, 0);
    cmp("sw_reset_state", 32'(state), 32'd0);
    cmp("sw_reset_outs", 32'(outs), 32'(O_FNR));

    // Hand sequence: unused op code variant also flagged illegal
    drive(0, 6'b000001, 0, 1);
    drive(0, 6'b000001, 0, 1);
    cmp("ill2_pulse", 32'({state, illegal_op}), 32'({4'd1, 1'b1}));
    drive(0, 6'b000001, 0, 1);
    cmp("ill2_after", 32'({state, illegal_op}), 32'({4'd0, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
